// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - R-type issue/writeback unit driving a combinational RV64 ALU
module alu_issue_unit #(
    parameter int          XLEN      = 64,
    parameter logic [6:0]  OPCODE_OP = 7'b0110011
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_rd,
    output logic            retire_valid,
    output logic [4:0]      retire_rd_addr,
    output logic [XLEN-1:0] retire_data,
    output logic            illegal,
    input  logic            dbg_we,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETIRE = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] regs [0:31];

    logic [6:0]      dec_op;
    logic [2:0]      dec_f3;
    logic [6:0]      dec_f7;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_legal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign dec_op  = instr[6:0];
    assign dec_rd  = instr[11:7];
    assign dec_f3  = instr[14:12];
    assign dec_rs1 = instr[19:15];
    assign dec_rs2 = instr[24:20];
    assign dec_f7  = instr[31:25];

    // Only base OP encodings plus SUB/SRA are accepted.
    assign dec_legal = (dec_op == OPCODE_OP) &&
                       ((dec_f7 == 7'b0000000) ||
                        ((dec_f7 == 7'b0100000) &&
                         ((dec_f3 == 3'b000) || (dec_f3 == 3'b101))));

    assign rs1_val   = (dec_rs1 == 5'd0) ? '0 : regs[dec_rs1];
    assign rs2_val   = (dec_rs2 == 5'd0) ? '0 : regs[dec_rs2];
    assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    assign instr_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rd_q           <= 5'd0;
            alu_funct3     <= 3'd0;
            alu_funct7     <= 7'd0;
            alu_rs1        <= '0;
            alu_rs2        <= '0;
            retire_valid   <= 1'b0;
            retire_rd_addr <= 5'd0;
            retire_data    <= '0;
            illegal        <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            retire_valid <= 1'b0;
            illegal      <= 1'b0;

            // Writeback below is assigned later, so it wins on an index collision.
            if (dbg_we && (dbg_addr != 5'd0)) begin
                regs[dbg_addr] <= dbg_wdata;
            end

            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (dec_legal) begin
                            alu_funct3 <= dec_f3;
                            alu_funct7 <= dec_f7;
                            alu_rs1    <= rs1_val;
                            alu_rs2    <= rs2_val;
                            rd_q       <= dec_rd;
                            state      <= ISSUE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    retire_data    <= alu_rd;
                    retire_rd_addr <= rd_q;
                    retire_valid   <= 1'b1;
                    if (rd_q != 5'd0) begin
                        regs[rd_q] <= alu_rd;
                    end
                    state <= RETIRE;
                end
                RETIRE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed self-checking bench for alu_issue_unit
module tb_alu_issue_unit;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [2:0]      alu_funct3;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [XLEN-1:0] alu_rd;
    logic            retire_valid;
    logic [4:0]      retire_rd_addr;
    logic [XLEN-1:0] retire_data;
    logic            illegal;
    logic            dbg_we;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic [XLEN-1:0] dbg_rdata;

    int checks;
    int errors;

    alu_issue_unit #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .alu_funct3     (alu_funct3),
        .alu_funct7     (alu_funct7),
        .alu_rs1        (alu_rs1),
        .alu_rs2        (alu_rs2),
        .alu_rd         (alu_rd),
        .retire_valid   (retire_valid),
        .retire_rd_addr (retire_rd_addr),
        .retire_data    (retire_data),
        .illegal        (illegal),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_rdata      (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU on the consumer side.
    always_comb begin
        alu_rd = '0;
        case (alu_funct3)
            3'b000: alu_rd = alu_funct7[5] ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
            3'b001: alu_rd = alu_rs1 << alu_rs2[5:0];
            3'b010: alu_rd = {63'd0, $signed(alu_rs1) < $signed(alu_rs2)};
            3'b011: alu_rd = {63'd0, alu_rs1 < alu_rs2};
            3'b100: alu_rd = alu_rs1 ^ alu_rs2;
            3'b101: alu_rd = alu_funct7[5] ? XLEN'($signed(alu_rs1) >>> alu_rs2[5:0])
                                           : alu_rs1 >> alu_rs2[5:0];
            3'b110: alu_rd = alu_rs1 | alu_rs2;
            default: alu_rd = alu_rs1 & alu_rs2;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [63:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    task automatic dbg_check(input string tag, input logic [4:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_retire_valid", retire_valid, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_alu_rs1", alu_rs1, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: SUB x3,x1,x2
        dbg_write(5'd1, 64'd5);
        dbg_write(5'd2, 64'd3);
        dbg_check("t1_x1", 5'd1, 64'd5);
        instr_valid = 1'b1; instr = 32'h402081B3;
        @(negedge clk);
        instr_valid = 1'b0;
        check("t1_ready_issue", instr_ready, 1'b0);
        check("t1_f7", alu_funct7, 7'b0100000);
        check("t1_f3", alu_funct3, 3'b000);
        check("t1_rs1", alu_rs1, 64'd5);
        check("t1_rs2", alu_rs2, 64'd3);
        check("t1_no_early_retire", retire_valid, 1'b0);
        @(negedge clk);
        check("t1_retire_valid", retire_valid, 1'b1);
        check("t1_rd_addr", retire_rd_addr, 5'd3);
        check("t1_data", retire_data, 64'd2);
        @(negedge clk);
        check("t1_retire_pulse_end", retire_valid, 1'b0);
        check("t1_ready_idle", instr_ready, 1'b1);
        dbg_check("t1_x3", 5'd3, 64'd2);

        // 2: ADD x0,x1,x2
        instr_valid = 1'b1; instr = 32'h00208033;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("t2_retire_valid", retire_valid, 1'b1);
        check("t2_rd_addr", retire_rd_addr, 5'd0);
        check("t2_data", retire_data, 64'd8);
        @(negedge clk);
        dbg_check("t2_x0", 5'd0, 64'd0);

        // 3: illegal encodings
        instr_valid = 1'b1; instr = 32'h00108093;
        @(negedge clk);
        instr_valid = 1'b0;
        check("t3a_illegal", illegal, 1'b1);
        check("t3a_ready", instr_ready, 1'b1);
        check("t3a_no_retire", retire_valid, 1'b0);
        check("t3a_alu_hold", alu_funct7, 7'b0000000);
        @(negedge clk);
        check("t3a_illegal_pulse_end", illegal, 1'b0);
        instr_valid = 1'b1; instr = 32'h402090B3;
        @(negedge clk);
        instr_valid = 1'b0;
        check("t3b_illegal", illegal, 1'b1);
        check("t3b_f3_hold", alu_funct3, 3'b000);
        @(negedge clk);
        check("t3b_no_retire", retire_valid, 1'b0);
        dbg_check("t3_x1", 5'd1, 64'd5);

        // 4: back-to-back SUB x4,x1,x2 then SUB x5,x4,x2 with valid held
        instr_valid = 1'b1; instr = 32'h40208233;
        @(negedge clk);
        check("t4_ready_issue1", instr_ready, 1'b0);
        instr = 32'h402202B3;
        @(negedge clk);
        check("t4_ready_retire1", instr_ready, 1'b0);
        check("t4_rv1", retire_valid, 1'b1);
        check("t4_rd1", retire_rd_addr, 5'd4);
        check("t4_data1", retire_data, 64'd2);
        check("t4_not_taken_early", alu_rs1, 64'd5);
        @(negedge clk);
        check("t4_ready_idle", instr_ready, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        check("t4_ready_issue2", instr_ready, 1'b0);
        check("t4_rs1_2", alu_rs1, 64'd2);
        check("t4_rs2_2", alu_rs2, 64'd3);
        @(negedge clk);
        check("t4_rv2", retire_valid, 1'b1);
        check("t4_rd2", retire_rd_addr, 5'd5);
        check("t4_data2", retire_data, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);

        // 5: reset during ISSUE
        instr_valid = 1'b1; instr = 32'h402081B3;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_ready", instr_ready, 1'b1);
        check("t5_f7", alu_funct7, 7'd0);
        check("t5_rs1", alu_rs1, 64'd0);
        check("t5_rs2", alu_rs2, 64'd0);
        check("t5_rd_addr", retire_rd_addr, 5'd0);
        check("t5_data", retire_data, 64'd0);
        @(negedge clk);
        check("t5_no_retire", retire_valid, 1'b0);
        for (int i = 1; i < 32; i++) begin
            dbg_check($sformatf("t5_x%0d", i), 5'(i), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_retire_after", retire_valid, 1'b0);
        dbg_write(5'd1, 64'd7);
        dbg_write(5'd2, 64'd4);
        instr_valid = 1'b1; instr = 32'h002081B3;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("t5_post_rv", retire_valid, 1'b1);
        check("t5_post_data", retire_data, 64'd11);
        @(negedge clk);

        // 6: debug/writeback collision, no same-cycle operand bypass, x0 debug write
        dbg_write(5'd1, 64'd5);
        dbg_write(5'd2, 64'd3);
        dbg_write(5'd0, 64'h1234);
        dbg_check("t6_x0_dbg", 5'd0, 64'd0);
        instr_valid = 1'b1; instr = 32'h402081B3;
        dbg_we = 1'b1; dbg_addr = 5'd1; dbg_wdata = 64'd9;
        @(negedge clk);
        instr_valid = 1'b0;
        check("t6_no_bypass", alu_rs1, 64'd5);
        dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 64'hAA;
        @(negedge clk);
        dbg_we = 1'b0;
        check("t6_data", retire_data, 64'd2);
        dbg_check("t6_x3_wb_wins", 5'd3, 64'd2);
        dbg_check("t6_x1_dbg", 5'd1, 64'd9);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
